// File: rtl/vp_pkg.sv
// Shared types and widths for the vector-processor writeback path.
package vp_pkg;

  localparam int unsigned SCALAR_W   = 21;
  localparam int unsigned VECTOR_W   = 192;
  localparam int unsigned NUM_REGS   = 6;
  localparam int unsigned REG_ADDR_W = 3;

  typedef enum logic {
    DES_SCALAR = 1'b0,
    DES_VECTOR = 1'b1
  } des_type_e;

  typedef struct packed {
    des_type_e               des_type;
    logic [REG_ADDR_W-1:0]   dest;
    logic [VECTOR_W-1:0]     payload;
  } wb_entry_t;

  // Scalar results are zero-extended so the payload is always VECTOR_W wide.
  function automatic wb_entry_t make_entry(input logic                  is_vec,
                                           input logic [REG_ADDR_W-1:0] dest,
                                           input logic [SCALAR_W-1:0]   scalar,
                                           input logic [VECTOR_W-1:0]   vector);
    wb_entry_t e;
    e.des_type = des_type_e'(is_vec);
    e.dest     = dest;
    e.payload  = is_vec ? vector : {{(VECTOR_W-SCALAR_W){1'b0}}, scalar};
    return e;
  endfunction

endpackage

// File: rtl/wbq_storage.sv
// DEPTH-entry FIFO of writeback entries with per-slot visibility for hazard lookup.
module wbq_storage
  import vp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         entry_valid,
  output wb_entry_t                entries [DEPTH]
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  wb_entry_t        mem_q [DEPTH];
  logic             push_en, pop_en;

  assign full    = (count_q == (PW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    valid_d  = valid_q;
    count_d  = count_q;
    // Pointers are PW bits wide, so the increment wraps modulo DEPTH.
    if (push_en) begin
      wr_ptr_d          = wr_ptr_q + 1'b1;
      valid_d[wr_ptr_q] = 1'b1;
    end
    if (pop_en) begin
      rd_ptr_d          = rd_ptr_q + 1'b1;
      valid_d[rd_ptr_q] = 1'b0;
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_entry;
  end

  assign head        = mem_q[rd_ptr_q];
  assign count       = count_q;
  assign entry_valid = valid_q;
  assign entries     = mem_q;

endmodule

// File: rtl/reg_writeback_queue.sv
// Writeback queue between execute and the register file: filters illegal
// destinations, drives the write port from the head, answers hazard queries.
module reg_writeback_queue
  import vp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2:0]              in_dest,
  input  logic                    in_desType,
  input  logic [20:0]             in_scalar,
  input  logic [191:0]            in_vector,
  input  logic                    wr_stall,
  output logic                    Reg_write,
  output logic [2:0]              A3,
  output logic                    desType,
  output logic [20:0]             wd3e,
  output logic [191:0]            wd3v,
  input  logic [2:0]              q_addr,
  input  logic                    q_type,
  output logic                    q_pending,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    err_illegal
);

  wb_entry_t        head;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] entry_valid;
  logic             full, empty;
  logic             accept, legal, push;
  logic             err_q, err_d;

  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign legal    = (32'(in_dest) < NUM_REGS);
  assign push     = accept && legal;
  assign err_d    = accept && !legal;

  wbq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_entry  (make_entry(in_desType, in_dest, in_scalar, in_vector)),
    .pop         (Reg_write),
    .head        (head),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .entry_valid (entry_valid),
    .entries     (entries)
  );

  assign Reg_write = !empty && !wr_stall;
  assign A3        = empty ? '0 : head.dest;
  assign desType   = empty ? 1'b0 : logic'(head.des_type);
  assign wd3v      = empty ? '0 : head.payload;
  assign wd3e      = empty ? '0 : head.payload[SCALAR_W-1:0];

  // The head stays valid until the edge that pops it, so it is still reported here.
  always_comb begin
    q_pending = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i] && entries[i].dest == q_addr &&
          logic'(entries[i].des_type) == q_type)
        q_pending = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_illegal = err_q;

endmodule
